// File: rtl/thermo_log_writer.sv
// Temperature sample logger: buffers sequence-numbered sensor samples in a small
// FIFO and drains them as single Avalon-MM writes into a circular on-chip SRAM log.
module thermo_log_writer #(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              smp_valid,
  input  logic [15:0]       smp_data,
  input  logic              log_enable,
  output logic [ADDR_W-1:0] m_address,
  output logic [3:0]        m_byteenable,
  output logic              m_chipselect,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  input  logic              m_waitrequest,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrapped,
  output logic [15:0]       dropped_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, WRITE} state_t;
  state_t state_reg, state_next;

  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_idx_reg;
  logic [PTR_W-1:0]  wr_idx_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [15:0]       seq_reg;
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic              wrapped_reg;
  logic [15:0]       dropped_reg;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  // Fullness uses the registered count, so a pop in the same cycle cannot rescue a sample.
  assign fifo_full  = (count_reg == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign push       = smp_valid && !fifo_full;
  assign pop        = (state_reg == WRITE) && !m_waitrequest;

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      fifo_mem[wr_idx_reg] <= {seq_reg, smp_data};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      rd_idx_reg  <= '0;
      wr_idx_reg  <= '0;
      count_reg   <= '0;
      seq_reg     <= '0;
      wr_ptr_reg  <= '0;
      wrapped_reg <= 1'b0;
      dropped_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Dropped samples still consume a sequence number so gaps show in the log.
      if (smp_valid) begin
        seq_reg <= seq_reg + 16'd1;
      end
      if (smp_valid && fifo_full && (dropped_reg != 16'hFFFF)) begin
        dropped_reg <= dropped_reg + 16'd1;
      end
      if (push) begin
        wr_idx_reg <= wr_idx_reg + 1'b1;
      end
      if (pop) begin
        rd_idx_reg <= rd_idx_reg + 1'b1;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (&wr_ptr_reg) begin
          wrapped_reg <= 1'b1;
        end
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_comb begin
    state_next   = state_reg;
    m_chipselect = 1'b0;
    m_write      = 1'b0;
    m_byteenable = 4'h0;
    m_address    = '0;
    m_writedata  = '0;
    case (state_reg)
      IDLE: begin
        if (log_enable && !fifo_empty) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        // Head and wr_ptr only move on acceptance, so these hold through a stall.
        m_chipselect = 1'b1;
        m_write      = 1'b1;
        m_byteenable = 4'hF;
        m_address    = wr_ptr_reg;
        m_writedata  = fifo_mem[rd_idx_reg];
        if (!m_waitrequest) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_ptr      = wr_ptr_reg;
  assign wrapped     = wrapped_reg;
  assign dropped_cnt = dropped_reg;

endmodule

// File: doc/thermo_log_writer.md
THERMO_LOG_WRITER -- requirements
Module: thermo_log_writer

Interface
REQ-001 Parameter: ADDR_W, 10, word-address width of the target on-chip SRAM; 1024 words.
REQ-002 Parameter: FIFO_DEPTH, 4, sample buffer entries; power of two, at least 2.
REQ-003 clk  in  1  single clock for all logic.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 smp_valid  in  1  temperature sample present this cycle; the sensor cannot stall.
REQ-006 smp_data  in  16  signed temperature sample.
REQ-007 log_enable  in  1  permits SRAM writes while high.
REQ-008 m_address  out  ADDR_W  SRAM word address.
REQ-009 m_byteenable  out  4  byte lanes.
REQ-010 m_chipselect  out  1  Avalon-MM chip select.
REQ-011 m_write  out  1  Avalon-MM write strobe.
REQ-012 m_writedata  out  32  log word.
REQ-013 m_waitrequest  in  1  interconnect stall.
REQ-014 wr_ptr  out  ADDR_W  next SRAM word to be written.
REQ-015 wrapped  out  1  sticky; set once the log has wrapped.
REQ-016 dropped_cnt  out  16  saturating count of samples lost to overflow.

Function
REQ-017 Accept and sequence numbering:
- Every cycle with smp_valid=1 SHALL be an accepted sample.
- Each accepted sample takes the current 16-bit sequence counter value.
- The counter then increments by 1 and wraps from 0xFFFF to 0x0000.
- Dropped samples also consume a sequence number, so gaps are visible in the log.
REQ-018 Push: an accepted sample SHALL be pushed into the FIFO as {seq[15:0], smp_data[15:0]}.
REQ-019 Overflow:
- Fullness SHALL be evaluated on the FIFO count at the start of the cycle.
- If the FIFO is full, the sample SHALL be discarded and dropped_cnt incremented, saturating at 0xFFFF.
- A pop in the same cycle does not prevent the drop.
REQ-020 Simultaneous push and pop on a non-full FIFO SHALL leave the count unchanged and preserve order.
REQ-021 The FSM SHALL have two states: IDLE and WRITE.
REQ-022 IDLE -> WRITE on the clock edge where log_enable=1 and the FIFO is non-empty:
- m_chipselect=1, m_write=1, m_byteenable=4'hF.
- m_address=wr_ptr.
- m_writedata=FIFO head.
REQ-023 WRITE, m_waitrequest=1: all m_* outputs SHALL be held stable.
REQ-024 WRITE, m_waitrequest=0 (write accepted, one transfer):
- Pop the FIFO head.
- Increment wr_ptr.
- Deassert m_chipselect and m_write.
- Return to IDLE.
- Maximum throughput is therefore one write every 2 cycles.
REQ-025 Wrap: when wr_ptr is 2^ADDR_W-1 at write acceptance, wr_ptr SHALL become 0 and wrapped SHALL set to 1; wrapped stays 1 until reset.
REQ-026 log_enable falling during WRITE: the write SHALL complete per REQ-024 and no new write starts; the FIFO keeps accepting and dropping per REQ-017 to REQ-019.
REQ-027 Outside WRITE: m_chipselect=0, m_write=0, m_byteenable=0, m_writedata=0.

Reset
REQ-028 reset=1 at a clock edge SHALL force the following, regardless of any in-flight write:
- FSM to IDLE, FIFO empty.
- Sequence counter, wr_ptr and dropped_cnt to 0; wrapped to 0.
- All m_* outputs to 0.
REQ-029 A sample with smp_valid=1 in a reset cycle SHALL be discarded and SHALL NOT be counted as dropped.

Verification
REQ-030 The bench SHALL cover the following directed scenarios:
- Single sample: log_enable=1, waitrequest=0, sample 0x0123 -> one write, address 0, data 0x00000123, byteenable F; wr_ptr=1.
- Stall: waitrequest held 3 cycles -> address, data and strobes stable for 4 cycles, then exactly one pop; wr_ptr advances by 1.
- Overflow: log_enable=0, 6 consecutive samples -> FIFO holds seq 0..3, dropped_cnt=2. After enabling, the log words carry seq 0,1,2,3.
- Wrap: wr_ptr preset by 1023 writes, then 2 samples -> writes to 1023 and 0; wrapped=1, wr_ptr=1.
- Reset mid-write: reset asserted while waitrequest=1 in WRITE -> next cycle all outputs 0, FIFO empty; a subsequent sample is written at address 0 with seq 0.
- Saturation: force 70000 drops -> dropped_cnt=0xFFFF and stays there.
